// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Function : Pipeline load enables, flushes and bubbles for the 5-stage core.
//            Handles load-use stalls, taken-branch flushes, data-memory wait
//            freezes, a sticky memory timeout, and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_MemRead,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_write,
  output logic                  exmem_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  memwb_bubble,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_count,
  output logic [1:0]            state
);

  localparam int c_wait_w = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_TIMEOUT  = 2'b10
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic [c_wait_w-1:0] w_wait_cnt_nxt;
  logic [CNT_W-1:0]    r_stall_count;
  logic                r_mem_timeout;

  logic w_freeze;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_lu;

  assign w_freeze = ((r_state == ST_RUN) && mem_req && !mem_ready) ||
                    ((r_state == ST_MEM_WAIT) && !mem_ready) ||
                    (r_state == ST_TIMEOUT);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  assign w_lu      = ex_MemRead && (ex_rd != '0) && (w_rs1_hit || w_rs2_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = c_wait_w'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == c_wait_max) begin
          w_state_nxt = ST_TIMEOUT;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + c_wait_w'(1);
        end
      end
      ST_TIMEOUT: begin
        w_state_nxt = ST_TIMEOUT;
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  // Priority: reset > freeze > taken branch > load-use > normal advance.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (w_freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_timeout <= 1'b0;
    end else if (w_state_nxt == ST_TIMEOUT) begin
      r_mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (!pc_write && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign mem_timeout = r_mem_timeout;
  assign stall_count = r_stall_count;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Function : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int REG_ADDR_W  = 5;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble}
  localparam logic [6:0] c_RESET  = 7'b0000000;
  localparam logic [6:0] c_FREEZE = 7'b0000001;
  localparam logic [6:0] c_BRANCH = 7'b1111110;
  localparam logic [6:0] c_LU     = 7'b0011010;
  localparam logic [6:0] c_NORM   = 7'b1111000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rd;
  logic                  id_use_rs1, id_use_rs2, ex_MemRead, ex_branch_taken;
  logic                  mem_req, mem_ready;
  logic                  pc_write, ifid_write, idex_write, exmem_write;
  logic                  ifid_flush, idex_flush, memwb_bubble, mem_timeout;
  logic [CNT_W-1:0]      stall_count;
  logic [1:0]            state;
  logic [6:0]            ctl;

  int checks = 0;
  int errors = 0;

  assign ctl = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble};

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_ADDR_W (REG_ADDR_W),
    .CNT_W      (CNT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd          (ex_rd),
    .ex_MemRead     (ex_MemRead),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .idex_write     (idex_write),
    .exmem_write    (exmem_write),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .memwb_bubble   (memwb_bubble),
    .mem_timeout    (mem_timeout),
    .stall_count    (stall_count),
    .state          (state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_MemRead = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    #3;
    checks++; if (ctl !== c_RESET) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, c_RESET); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", mem_timeout); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_count); end
    tick();
    tick();
    checks++; if (ctl !== c_RESET) begin errors++; $display("FAIL reset_held_ctl got %b exp %b", ctl, c_RESET); end
    rst = 1'b0;
    #1;
    checks++; if (ctl !== c_NORM) begin errors++; $display("FAIL reset_release_ctl got %b exp %b", ctl, c_NORM); end
    tick();
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL reset_release_stall got %0d exp 0", stall_count); end
  endtask

  task automatic test_load_use;
    ex_MemRead = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1;
    checks++; if (ctl !== c_LU) begin errors++; $display("FAIL lu_rs2_ctl got %b exp %b", ctl, c_LU); end
    tick();
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_rs2_stall got %0d exp 1", stall_count); end
    clear_inputs();
    #1;
    checks++; if (ctl !== c_NORM) begin errors++; $display("FAIL lu_after_ctl got %b exp %b", ctl, c_NORM); end
    tick();
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_after_stall got %0d exp 1", stall_count); end
    ex_MemRead = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
    #1;
    checks++; if (ctl !== c_LU) begin errors++; $display("FAIL lu_rs1_ctl got %b exp %b", ctl, c_LU); end
    tick();
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL lu_rs1_stall got %0d exp 2", stall_count); end
    id_use_rs1 = 1'b0;
    #1;
    checks++; if (ctl !== c_NORM) begin errors++; $display("FAIL lu_unused_rs1_ctl got %b exp %b", ctl, c_NORM); end
    tick();
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL lu_unused_rs1_stall got %0d exp 2", stall_count); end
    clear_inputs();
  endtask

  task automatic test_rd_zero;
    ex_MemRead = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    checks++; if (ctl !== c_NORM) begin errors++; $display("FAIL rd0_ctl got %b exp %b", ctl, c_NORM); end
    tick();
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL rd0_stall got %0d exp 2", stall_count); end
    ex_MemRead = 1'b0; ex_rd = 5'd12; id_rs1 = 5'd12;
    #1;
    checks++; if (ctl !== c_NORM) begin errors++; $display("FAIL noload_ctl got %b exp %b", ctl, c_NORM); end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_lu;
    ex_MemRead = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; ex_branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== c_BRANCH) begin errors++; $display("FAIL branch_lu_ctl got %b exp %b", ctl, c_BRANCH); end
    tick();
    checks++; if (stall_count !== 4'd2) begin errors++; $display("FAIL branch_lu_stall got %0d exp 2", stall_count); end
    clear_inputs();
  endtask

  task automatic test_mem_wait;
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== c_NORM) begin errors++; $display("FAIL mem_hit_ctl got %b exp %b", ctl, c_NORM); end
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL mem_hit_state got %b exp 00", state); end
    mem_ready = 1'b0;
    #1;
    checks++; if (ctl !== c_FREEZE) begin errors++; $display("FAIL wait1_ctl got %b exp %b", ctl, c_FREEZE); end
    tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL wait1_state got %b exp 01", state); end
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL wait1_stall got %0d exp 1", stall_count); end
    ex_branch_taken = 1'b1;
    #1;
    checks++; if (ctl !== c_FREEZE) begin errors++; $display("FAIL wait2_branch_ctl got %b exp %b", ctl, c_FREEZE); end
    tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL wait2_state got %b exp 01", state); end
    #1;
    checks++; if (ctl !== c_FREEZE) begin errors++; $display("FAIL wait3_ctl got %b exp %b", ctl, c_FREEZE); end
    tick();
    checks++; if (stall_count !== 4'd3) begin errors++; $display("FAIL wait3_stall got %0d exp 3", stall_count); end
    mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== c_BRANCH) begin errors++; $display("FAIL ready_branch_ctl got %b exp %b", ctl, c_BRANCH); end
    tick();
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL ready_state got %b exp 00", state); end
    checks++; if (stall_count !== 4'd3) begin errors++; $display("FAIL ready_stall got %0d exp 3", stall_count); end
    clear_inputs();
  endtask

  task automatic test_timeout;
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (ctl !== c_FREEZE) begin errors++; $display("FAIL to_freeze%0d_ctl got %b exp %b", i, ctl, c_FREEZE); end
      if (i == 4) begin
        checks++; if (state !== 2'b01 || mem_timeout !== 1'b0) begin errors++; $display("FAIL to_pre got state %b err %b exp 01 0", state, mem_timeout); end
      end
      tick();
    end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL to_state got %b exp 10", state); end
    checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b exp 1", mem_timeout); end
    checks++; if (stall_count !== 4'd5) begin errors++; $display("FAIL to_stall got %0d exp 5", stall_count); end
    mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== c_FREEZE) begin errors++; $display("FAIL to_ready_ctl got %b exp %b", ctl, c_FREEZE); end
    tick();
    checks++; if (state !== 2'b10 || mem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got state %b err %b exp 10 1", state, mem_timeout); end
    checks++; if (stall_count !== 4'd6) begin errors++; $display("FAIL to_sticky_stall got %0d exp 6", stall_count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (state !== 2'b00 || mem_timeout !== 1'b0) begin errors++; $display("FAIL to_rst got state %b err %b exp 00 0", state, mem_timeout); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL to_rst_stall got %0d exp 0", stall_count); end
    checks++; if (ctl !== c_RESET) begin errors++; $display("FAIL to_rst_ctl got %b exp %b", ctl, c_RESET); end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_ready_last;
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL last_wait_state got %b exp 01", state); end
    mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== c_NORM) begin errors++; $display("FAIL last_ready_ctl got %b exp %b", ctl, c_NORM); end
    tick();
    checks++; if (state !== 2'b00 || mem_timeout !== 1'b0) begin errors++; $display("FAIL last_ready got state %b err %b exp 00 0", state, mem_timeout); end
    checks++; if (stall_count !== 4'd4) begin errors++; $display("FAIL last_ready_stall got %0d exp 4", stall_count); end
    clear_inputs();
  endtask

  task automatic test_saturation;
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat15_stall got %0d exp 15", stall_count); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (stall_count !== 4'd15) begin errors++; $display("FAIL sat20_stall got %0d exp 15", stall_count); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL sat_state got %b exp 10", state); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_ready_last();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
